// File: rtl/core_bus_pkg.sv
// Shared types for the core bus arbiter: FSM states, master indices, request bundle.
package core_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RSP  = 2'd2
    } arb_state_e;

    localparam int MST_IBUS = 0;
    localparam int MST_DBUS = 1;
    localparam int NUM_MST  = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        we;
    } bus_req_t;

endpackage

// File: rtl/core_bus_arb_pick.sv
// Combinational winner select: dbus over ibus, unless the starvation flag forces ibus.
module core_bus_arb_pick
    import core_bus_pkg::*;
(
    input  logic [NUM_MST-1:0] req_valid_i,
    input  logic               force_ibus_i,
    output logic [NUM_MST-1:0] grant_o
);

    // one-hot winner; all-zero when nobody requests
    always_comb begin
        grant_o = '0;
        if (force_ibus_i && req_valid_i[MST_IBUS])
            grant_o[MST_IBUS] = 1'b1;
        else if (req_valid_i[MST_DBUS])
            grant_o[MST_DBUS] = 1'b1;
        else if (req_valid_i[MST_IBUS])
            grant_o[MST_IBUS] = 1'b1;
    end

endmodule

// File: rtl/core_bus_arb.sv
// Two-master (ibus=m0, dbus=m1) to one-slave arbiter, one outstanding transaction.
// Optional ibus starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module core_bus_arb
    import core_bus_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_req_valid_i,
    output logic        m0_req_ready_o,
    output logic        m0_rsp_valid_o,
    input  logic        m0_rsp_ready_i,
    output logic [31:0] m0_data_o,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_req_valid_i,
    output logic        m1_req_ready_o,
    output logic        m1_rsp_valid_o,
    input  logic        m1_rsp_ready_i,
    output logic [31:0] m1_data_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_req_valid_o,
    input  logic        s_req_ready_i,
    input  logic        s_rsp_valid_i,
    output logic        s_rsp_ready_o,
    input  logic [31:0] s_data_i,
    output logic [1:0]  grant_o,
    output logic        busy_o
);

    arb_state_e         state_q, state_d;
    logic [NUM_MST-1:0] grant_q, grant_d;
    logic [NUM_MST-1:0] req_valid, rsp_ready, pick_grant;
    bus_req_t           mreq [NUM_MST];
    bus_req_t           sreq;
    logic               in_req, in_rsp, gnt_req_valid, gnt_rsp_ready, rsp_hs;
    logic               starve_force;

    assign req_valid = {m1_req_valid_i, m0_req_valid_i};
    assign rsp_ready = {m1_rsp_ready_i, m0_rsp_ready_i};

    // gather master request fields into structs
    always_comb begin
        mreq[MST_IBUS] = '{addr: m0_addr_i, data: m0_data_i, sel: m0_sel_i, we: m0_we_i};
        mreq[MST_DBUS] = '{addr: m1_addr_i, data: m1_data_i, sel: m1_sel_i, we: m1_we_i};
    end

    assign in_req        = (state_q == ARB_REQ);
    assign in_rsp        = (state_q == ARB_RSP);
    assign gnt_req_valid = |(grant_q & req_valid);
    assign gnt_rsp_ready = |(grant_q & rsp_ready);
    assign rsp_hs        = in_rsp && s_rsp_valid_i && gnt_rsp_ready;

    core_bus_arb_pick u_pick (
        .req_valid_i  (req_valid),
        .force_ibus_i (starve_force),
        .grant_o      (pick_grant)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                arb_en;

    // an arbitration happens from IDLE or on the RSP handshake, whenever someone requests
    assign arb_en       = (|req_valid) && ((state_q == ARB_IDLE) || rsp_hs);
    assign starve_force = (starve_q == STARVE_MAX);

    // count ibus losses (saturating); any ibus grant clears the count
    always_comb begin
        starve_d = starve_q;
        if (arb_en) begin
            if (pick_grant[MST_IBUS])
                starve_d = '0;
            else if (req_valid[MST_IBUS] && (starve_q != STARVE_MAX))
                starve_d = starve_q + 1'b1;
        end
    end

    // starvation counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_q <= '0;
        else        starve_q <= starve_d;
    end
`else
    assign starve_force = 1'b0;
`endif

    // next state and grant; RSP handshake re-arbitrates on the same edge
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (|req_valid) begin
                    state_d = ARB_REQ;
                    grant_d = pick_grant;
                end
            end
            ARB_REQ: begin
                if (!gnt_req_valid) begin
                    // granted master withdrew its request: abandon the grant
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end else if (s_req_ready_i) begin
                    state_d = ARB_RSP;
                end
            end
            ARB_RSP: begin
                if (rsp_hs) begin
                    if (|req_valid) begin
                        state_d = ARB_REQ;
                        grant_d = pick_grant;
                    end else begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // state and grant registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // slave-side request mux; fields are zero unless a request phase is active
    always_comb begin
        sreq = '0;
        if (in_req) begin
            if (grant_q[MST_DBUS])      sreq = mreq[MST_DBUS];
            else if (grant_q[MST_IBUS]) sreq = mreq[MST_IBUS];
        end
    end

    assign s_addr_o      = sreq.addr;
    assign s_data_o      = sreq.data;
    assign s_sel_o       = sreq.sel;
    assign s_we_o        = sreq.we;
    assign s_req_valid_o = in_req && gnt_req_valid;
    assign s_rsp_ready_o = in_rsp && gnt_rsp_ready;

    // handshakes routed only to the granted master
    assign m0_req_ready_o = in_req && s_req_ready_i && grant_q[MST_IBUS];
    assign m1_req_ready_o = in_req && s_req_ready_i && grant_q[MST_DBUS];
    assign m0_rsp_valid_o = in_rsp && s_rsp_valid_i && grant_q[MST_IBUS];
    assign m1_rsp_valid_o = in_rsp && s_rsp_valid_i && grant_q[MST_DBUS];
    assign m0_data_o      = s_data_i;
    assign m1_data_o      = s_data_i;

    assign grant_o = grant_q;
    assign busy_o  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_core_bus_arb.sv
// Directed bench for core_bus_arb; starvation expectations follow ARB_STARVE_GUARD_EN.
module tb_core_bus_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i, s_data_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_we_i, m0_req_valid_i, m0_rsp_ready_i;
    logic        m1_we_i, m1_req_valid_i, m1_rsp_ready_i;
    logic        s_req_ready_i, s_rsp_valid_i;
    logic        m0_req_ready_o, m0_rsp_valid_o, m1_req_ready_o, m1_rsp_valid_o;
    logic [31:0] m0_data_o, m1_data_o, s_addr_o, s_data_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_req_valid_o, s_rsp_ready_o, busy_o;
    logic [1:0]  grant_o;

    int n_chk  = 0;
    int n_fail = 0;

    core_bus_arb #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_req_valid_i(m0_req_valid_i), .m0_req_ready_o(m0_req_ready_o),
        .m0_rsp_valid_o(m0_rsp_valid_o), .m0_rsp_ready_i(m0_rsp_ready_i), .m0_data_o(m0_data_o),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_req_valid_i(m1_req_valid_i), .m1_req_ready_o(m1_req_ready_o),
        .m1_rsp_valid_o(m1_rsp_valid_o), .m1_rsp_ready_i(m1_rsp_ready_i), .m1_data_o(m1_data_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_req_valid_o(s_req_valid_o), .s_req_ready_i(s_req_ready_i),
        .s_rsp_valid_i(s_rsp_valid_i), .s_rsp_ready_o(s_rsp_ready_o), .s_data_i(s_data_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_g;
        rst_n = 1'b0;
        m0_addr_i = '0; m0_data_i = '0; m0_sel_i = '0; m0_we_i = 1'b0;
        m0_req_valid_i = 1'b0; m0_rsp_ready_i = 1'b0;
        m1_addr_i = '0; m1_data_i = '0; m1_sel_i = '0; m1_we_i = 1'b0;
        m1_req_valid_i = 1'b0; m1_rsp_ready_i = 1'b0;
        s_req_ready_i = 1'b0; s_rsp_valid_i = 1'b0; s_data_i = '0;
        #1;
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_s_req_valid", 32'(s_req_valid_o), 32'h0);
        chk("rst_s_addr", s_addr_o, 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // m0 read alone, zero-wait slave (s_rsp_valid held high; ignored outside RSP)
        m0_addr_i = 32'h0000_0100; m0_req_valid_i = 1'b1; m0_rsp_ready_i = 1'b1;
        s_req_ready_i = 1'b1; s_rsp_valid_i = 1'b1; s_data_i = 32'hA5A5_0001;
        #1;
        chk("m0_c0_grant", 32'(grant_o), 32'h0);
        chk("m0_c0_s_req_valid", 32'(s_req_valid_o), 32'h0);
        step();
        chk("m0_c1_grant", 32'(grant_o), 32'h1);
        chk("m0_c1_s_req_valid", 32'(s_req_valid_o), 32'h1);
        chk("m0_c1_s_addr", s_addr_o, 32'h0000_0100);
        chk("m0_c1_req_ready", 32'(m0_req_ready_o), 32'h1);
        chk("m0_c1_m1_req_ready", 32'(m1_req_ready_o), 32'h0);
        chk("m0_c1_rsp_valid", 32'(m0_rsp_valid_o), 32'h0);
        step();
        m0_req_valid_i = 1'b0;
        #1;
        chk("m0_c2_rsp_valid", 32'(m0_rsp_valid_o), 32'h1);
        chk("m0_c2_data", m0_data_o, 32'hA5A5_0001);
        chk("m0_c2_m1_rsp_valid", 32'(m1_rsp_valid_o), 32'h0);
        chk("m0_c2_s_rsp_ready", 32'(s_rsp_ready_o), 32'h1);
        step();
        chk("m0_c3_busy", 32'(busy_o), 32'h0);
        chk("m0_c3_grant", 32'(grant_o), 32'h0);

        // simultaneous requests: m1 write first, m0 follows with no IDLE gap
        m0_addr_i = 32'h0000_0300; m0_req_valid_i = 1'b1;
        m1_addr_i = 32'h0000_2000; m1_data_i = 32'hDEAD_BEEF; m1_sel_i = 4'hF; m1_we_i = 1'b1;
        m1_req_valid_i = 1'b1; m1_rsp_ready_i = 1'b1;
        step();
        chk("sim_grant_m1", 32'(grant_o), 32'h2);
        chk("sim_s_we", 32'(s_we_o), 32'h1);
        chk("sim_s_addr", s_addr_o, 32'h0000_2000);
        chk("sim_s_data", s_data_o, 32'hDEAD_BEEF);
        chk("sim_s_sel", 32'(s_sel_o), 32'hF);
        chk("sim_m0_req_ready", 32'(m0_req_ready_o), 32'h0);
        step();
        m1_req_valid_i = 1'b0; m1_we_i = 1'b0;
        #1;
        chk("sim_m1_rsp_valid", 32'(m1_rsp_valid_o), 32'h1);
        chk("sim_m0_rsp_valid", 32'(m0_rsp_valid_o), 32'h0);
        step();
        chk("sim_grant_m0", 32'(grant_o), 32'h1);
        chk("sim_m0_s_req_valid", 32'(s_req_valid_o), 32'h1);
        chk("sim_m0_s_addr", s_addr_o, 32'h0000_0300);
        chk("sim_m0_s_we", 32'(s_we_o), 32'h0);
        step();
        m0_req_valid_i = 1'b0;
        #1;
        chk("sim_m0_rsp", 32'(m0_rsp_valid_o), 32'h1);
        step();
        chk("sim_end_busy", 32'(busy_o), 32'h0);

        // slave stalls the request for 3 cycles
        s_req_ready_i = 1'b0;
        m1_addr_i = 32'h0000_1234; m1_data_i = 32'h0BAD_F00D; m1_req_valid_i = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("stall_grant", 32'(grant_o), 32'h2);
            chk("stall_s_addr", s_addr_o, 32'h0000_1234);
            chk("stall_s_data", s_data_o, 32'h0BAD_F00D);
            chk("stall_m1_req_ready", 32'(m1_req_ready_o), 32'h0);
            chk("stall_m1_rsp_valid", 32'(m1_rsp_valid_o), 32'h0);
            step();
        end
        s_req_ready_i = 1'b1;
        #1;
        chk("stall_release_ready", 32'(m1_req_ready_o), 32'h1);
        step();
        m1_req_valid_i = 1'b0;
        #1;
        chk("stall_rsp_valid", 32'(m1_rsp_valid_o), 32'h1);
        step();
        chk("stall_end_busy", 32'(busy_o), 32'h0);

        // m0 holds off its response for 2 cycles
        m0_addr_i = 32'h0000_0400; m0_req_valid_i = 1'b1; m0_rsp_ready_i = 1'b0;
        s_data_i = 32'h1357_9BDF;
        step();
        step();
        m0_req_valid_i = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("bp_s_rsp_ready", 32'(s_rsp_ready_o), 32'h0);
            chk("bp_busy", 32'(busy_o), 32'h1);
            chk("bp_rsp_valid", 32'(m0_rsp_valid_o), 32'h1);
            chk("bp_data", m0_data_o, 32'h1357_9BDF);
            step();
        end
        m0_rsp_ready_i = 1'b1;
        #1;
        chk("bp_release_ready", 32'(s_rsp_ready_o), 32'h1);
        step();
        chk("bp_end_busy", 32'(busy_o), 32'h0);

        // granted master withdraws its request before the slave accepts
        s_req_ready_i = 1'b0; m0_req_valid_i = 1'b1;
        step();
        chk("drop_grant", 32'(grant_o), 32'h1);
        m0_req_valid_i = 1'b0;
        #1;
        chk("drop_s_req_valid", 32'(s_req_valid_o), 32'h0);
        step();
        chk("drop_grant_clr", 32'(grant_o), 32'h0);
        chk("drop_busy", 32'(busy_o), 32'h0);

        // both masters request continuously; count arbitrations
        s_req_ready_i = 1'b1; s_rsp_valid_i = 1'b1;
        m0_req_valid_i = 1'b1; m1_req_valid_i = 1'b1;
        m0_rsp_ready_i = 1'b1; m1_rsp_ready_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
`ifdef ARB_STARVE_GUARD_EN
            exp_g = (k == 5) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b10;
`endif
            chk($sformatf("starve_arb%0d_grant", k), 32'(grant_o), 32'(exp_g));
            step();
        end
        m0_req_valid_i = 1'b0; m1_req_valid_i = 1'b0;
        step();
        chk("starve_end_busy", 32'(busy_o), 32'h0);

        // reset asserted while an m1 read response is pending
        m1_addr_i = 32'h0000_1000; m1_req_valid_i = 1'b1; m1_rsp_ready_i = 1'b0;
        step();
        step();
        m1_req_valid_i = 1'b0;
        #1;
        chk("rstmid_pre_busy", 32'(busy_o), 32'h1);
        chk("rstmid_pre_rsp_valid", 32'(m1_rsp_valid_o), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_grant", 32'(grant_o), 32'h0);
        chk("rstmid_busy", 32'(busy_o), 32'h0);
        chk("rstmid_m1_rsp_valid", 32'(m1_rsp_valid_o), 32'h0);
        chk("rstmid_s_rsp_ready", 32'(s_rsp_ready_o), 32'h0);
        chk("rstmid_s_req_valid", 32'(s_req_valid_o), 32'h0);
        chk("rstmid_s_addr", s_addr_o, 32'h0);
        chk("rstmid_s_we", 32'(s_we_o), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
